col_clk_gen: RTL and testbench
==============================

Name: col_clk_gen

Overview:
- Parametrised multi-channel colour-clock enable generator.
- Each channel uses a phase accumulator (DDS) on the single fabric clock to produce a fractional-rate clock-enable, e.g. a PAL or NTSC colour-clock x16 enable.
- Increments are runtime-reprogrammable through a valid/ready config port. A new increment takes effect only at the channel's next wrap, so the output never has a short period.
- Per-channel lock indication and a status byte replace the fixed-ratio, status-only DCM path used for video timing.

Parameters:
- NUM_CH, 2, number of independent channels (1..7).
- ACC_W, 24, accumulator and increment width in bits.
- PHASE_W, 4, width of phase output per channel (top bits of accumulator); PHASE_W <= ACC_W.
- DEFAULT_INC, 24'h0B_5A3C, increment loaded into every channel at reset.
- LOCK_CYCLES, 16, number of ce pulses after an increment change before locked asserts (>=1).

Ports:
- clk_in  input  1  fabric clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  NUM_CH  per-channel run enable.
- cfg_valid  input  1  config transfer request.
- cfg_ready  output  1  config accept; transfer occurs when cfg_valid && cfg_ready.
- cfg_ch  input  $clog2(NUM_CH+1)  target channel index.
- cfg_inc  input  ACC_W  new increment.
- ce  output  NUM_CH  one-cycle clock-enable pulse per wrap.
- phase  output  NUM_CH*PHASE_W  channel i at [i*PHASE_W +: PHASE_W]; registered acc MSBs.
- locked  output  NUM_CH  channel producing ce at its settled increment.
- status  output  8  [NUM_CH-1:0] pending flags; [7] sticky bad-channel error; other bits 0.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - acc=0, inc=DEFAULT_INC, pending=0, ce=0, locked=0, lock counter=0, status=0.
  - cfg_ready=1 once reset is released.
- Per channel, enabled: each cycle, {carry, acc} <= acc + inc (ACC_W+1-bit sum, carry discarded after use).
  - ce registered = carry; 1-cycle latency from the wrapping add.
  - phase = acc[ACC_W-1 -: PHASE_W] (registered).
- Per channel, disabled: acc cleared to 0, ce=0, locked=0, lock counter=0. If pending is set, pending_inc is copied into inc immediately and pending clears next cycle.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] for a valid index; 1 for an out-of-range index.
  - Accept with a valid index: pending_inc[ch] <= cfg_inc, pending[ch] <= 1, locked[ch] <= 0, lock counter cleared.
  - Accept with an out-of-range index: data dropped, status[7] set (sticky until reset).
- Pending apply (enabled channel): on the first carry cycle strictly after the accept cycle:
  - inc <= pending_inc and pending clears.
  - The wrapping add in that cycle still uses the old inc.
  - An accept coinciding with a carry cycle does not apply on that carry.
- Lock:
  - After reset, or after an apply, the counter increments on each ce while inc != 0 and no pending update exists.
  - locked asserts on the cycle the counter reaches LOCK_CYCLES, then saturates.
  - inc == 0: no ce, locked stays 0.
- Simultaneous events:
  - enable falling in the same cycle as an accept: the accept is honoured and the disabled rule applies.
  - Reset mid-operation: all state returns to reset values within the reset assertion, with no ce glitch.
- Arithmetic is unsigned modulo 2^ACC_W.
- Wrap frequency = f_clk * inc / 2^ACC_W.

Test Plan:
- ACC_W=8, DEFAULT_INC=64, enable=1 after reset release:
  - ce pulses every 4 cycles exactly.
  - phase (PHASE_W=2) steps 0,1,2,3.
  - locked rises on the 16th ce pulse.
- ACC_W=8, inc=96:
  - ce spacing pattern 3,3,2 repeats.
  - 3 pulses per 8 cycles, checked over 64 cycles (24 pulses).
- Running at inc=64, write cfg_inc=128 mid-period:
  - cfg_ready drops the next cycle; status[ch]=1.
  - The next wrap still follows the 4-cycle spacing; after that, spacing is 2.
  - locked drops at accept and re-asserts after 16 further pulses.
- Accept issued in the exact cycle of a carry: the new inc is applied at the following carry, not the current one.
- cfg_ch=NUM_CH (out of range) with cfg_valid=1: the handshake completes, status[7]=1, no channel changes, status[7] persists until reset_n low.
- Disable channel with pending set, then re-enable, then assert reset_n low mid-run:
  - Disabled: acc=0, ce=0, pending inc applied immediately.
  - Reset: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/col_clk_gen_if.sv
// Config port for col_clk_gen: one increment write per valid/ready transfer.
interface col_clk_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 24
);
    localparam int CH_W = $clog2(NUM_CH + 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (
        output cfg_valid, cfg_ch, cfg_inc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_inc,
        output cfg_ready
    );
endinterface

// File: rtl/col_clk_gen.sv
// Multi-channel DDS clock-enable generator with wrap-aligned increment
// updates, per-channel lock tracking and a status byte.
module col_clk_gen #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 24,
    parameter int               PHASE_W     = 4,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(24'h0B_5A3C),
    parameter int               LOCK_CYCLES = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         enable,
    col_clk_gen_if.slave              cfg,
    output logic [NUM_CH-1:0]         ce,
    output logic [NUM_CH*PHASE_W-1:0] phase,
    output logic [NUM_CH-1:0]         locked,
    output logic [7:0]                status
);
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [ACC_W-1:0] acc_q  [NUM_CH];
    logic [ACC_W-1:0] acc_d  [NUM_CH];
    logic [ACC_W-1:0] inc_q  [NUM_CH];
    logic [ACC_W-1:0] inc_d  [NUM_CH];
    logic [ACC_W-1:0] pinc_q [NUM_CH];
    logic [ACC_W-1:0] pinc_d [NUM_CH];
    logic [ACC_W:0]   sum    [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] lock_q, lock_d;
    logic              err_q, err_d;
    logic              ready;
    logic              fire;
    logic              bad_ch;

    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) ready = !pend_q[i];
        end
    end

    // Held low until the synchronised reset release reaches the core.
    assign cfg.cfg_ready = ready & rst_n;
    assign fire          = cfg.cfg_valid & cfg.cfg_ready;
    assign bad_ch        = cfg.cfg_ch >= CH_W'(NUM_CH);

    always_comb begin
        err_d = err_q | (fire & bad_ch);
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i]    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i]  = acc_q[i];
            inc_d[i]  = inc_q[i];
            pinc_d[i] = pinc_q[i];
            cnt_d[i]  = cnt_q[i];
            pend_d[i] = pend_q[i];
            ce_d[i]   = 1'b0;
            lock_d[i] = lock_q[i];
            if (!enable[i]) begin
                acc_d[i]  = '0;
                cnt_d[i]  = '0;
                lock_d[i] = 1'b0;
                if (pend_q[i]) begin
                    inc_d[i]  = pinc_q[i];
                    pend_d[i] = 1'b0;
                end
            end else begin
                acc_d[i] = sum[i][ACC_W-1:0];
                ce_d[i]  = sum[i][ACC_W];
                // Swap increments only on a wrap so no period is shortened.
                if (sum[i][ACC_W] && pend_q[i]) begin
                    inc_d[i]  = pinc_q[i];
                    pend_d[i] = 1'b0;
                end else if (sum[i][ACC_W] && inc_q[i] != '0 &&
                             cnt_q[i] != LOCK_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
                lock_d[i] = (cnt_d[i] == LOCK_MAX);
            end
            if (fire && cfg.cfg_ch == CH_W'(i)) begin
                pinc_d[i] = cfg.cfg_inc;
                pend_d[i] = 1'b1;
                cnt_d[i]  = '0;
                lock_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                inc_q[i]  <= DEFAULT_INC;
                pinc_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            pend_q <= '0;
            ce_q   <= '0;
            lock_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= acc_d[i];
                inc_q[i]  <= inc_d[i];
                pinc_q[i] <= pinc_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            pend_q <= pend_d;
            ce_q   <= ce_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            phase[i*PHASE_W +: PHASE_W] = acc_q[i][ACC_W-1 -: PHASE_W];
        end
    end

    always_comb begin
        status             = '0;
        status[NUM_CH-1:0] = pend_q;
        status[7]          = err_q;
    end

    assign ce     = ce_q;
    assign locked = lock_q;
endmodule

// File: tb/tb_col_clk_gen.sv
// Directed bench for col_clk_gen with ACC_W=8 so wrap spacing is easy
// to derive by hand.
module tb_col_clk_gen;
  logic       clk;
  logic       reset_n;
  logic [1:0] enable;
  logic [1:0] ce;
  logic [3:0] phase;
  logic [1:0] locked;
  logic [7:0] status;
  int         cyc;
  int         vecs;
  int         errs;
  int         t, tp, ts, ta, tb;

  col_clk_gen_if #(.NUM_CH(2), .ACC_W(8)) cfg_if ();

  col_clk_gen #(
    .NUM_CH     (2),
    .ACC_W      (8),
    .PHASE_W    (2),
    .DEFAULT_INC(8'd64),
    .LOCK_CYCLES(16)
  ) dut (
    .clk_in (clk),
    .reset_n(reset_n),
    .enable (enable),
    .cfg    (cfg_if),
    .ce     (ce),
    .phase  (phase),
    .locked (locked),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ce(input int ch, output int tt);
    tt = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (ce[ch]) begin
        tt = cyc;
        break;
      end
    end
    if (tt < 0) chk("ce_timeout", 0, 1);
  endtask

  task automatic cfg_drive(input logic [1:0] ch, input logic [7:0] inc);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_inc   = inc;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset_n = 1'b0;
    enable = 2'b01;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = 2'd0;
    cfg_if.cfg_inc = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ce", ce, 0);
    chk("rst_phase", phase, 0);
    chk("rst_locked", locked, 0);
    chk("rst_status", status, 0);
    reset_n = 1'b1;

    // inc=64: 4-cycle spacing, lock on the 16th pulse
    wait_ce(0, tp);
    chk("a_lock_1", locked[0], 0);
    for (int k = 2; k <= 16; k++) begin
      wait_ce(0, t);
      chk("a_gap", t - tp, 4);
      chk("a_lock", locked[0], (k >= 16));
      tp = t;
    end
    chk("a_ph0", phase[1:0], 0);
    @(negedge clk);
    chk("a_ph1", phase[1:0], 1);
    @(negedge clk);
    chk("a_ph2", phase[1:0], 2);
    @(negedge clk);
    chk("a_ph3", phase[1:0], 3);
    wait_ce(0, t);
    chk("a_gap17", t - tp, 4);
    chk("a_ph_wrap", phase[1:0], 0);
    tp = t;

    // mid-period reprogram to 128
    @(negedge clk);
    chk("c_rdy_pre", cfg_if.cfg_ready, 1);
    cfg_drive(2'd0, 8'd128);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("c_rdy_drop", cfg_if.cfg_ready, 0);
    chk("c_pend", status[0], 1);
    chk("c_unlock", locked[0], 0);
    wait_ce(0, t);
    chk("c_gap_old", t - tp, 4);
    chk("c_pend_clr", status[0], 0);
    chk("c_rdy_back", cfg_if.cfg_ready, 1);
    tp = t;
    for (int k = 1; k <= 16; k++) begin
      wait_ce(0, t);
      chk("c_gap_new", t - tp, 2);
      chk("c_relock", locked[0], (k >= 16));
      tp = t;
    end

    // accept in the carry cycle: old inc governs one more period
    @(negedge clk);
    chk("d_ph", phase[1:0], 2);
    cfg_drive(2'd0, 8'd64);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("d_ce", ce[0], 1);
    chk("d_pend", status[0], 1);
    ta = cyc;
    wait_ce(0, tb);
    chk("d_gap_old", tb - ta, 2);
    wait_ce(0, t);
    chk("d_gap_new", t - tb, 4);

    // ch1 programmed while disabled, then run at 96
    chk("b_rdy", cfg_if.cfg_ready, 1);
    cfg_drive(2'd1, 8'd96);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("b_pend", status[1], 1);
    @(negedge clk);
    chk("b_pend_clr", status[1], 0);
    chk("b_ph", phase[3:2], 0);
    chk("b_ce", ce[1], 0);
    enable = 2'b11;
    ts = cyc;
    tp = ts;
    for (int k = 0; k < 24; k++) begin
      wait_ce(1, t);
      chk("b_gap", t - tp, (k % 3 == 2) ? 2 : 3);
      tp = t;
    end
    chk("b_span", t - ts, 64);

    // out-of-range channel
    cfg_drive(2'd2, 8'h10);
    chk("e_rdy", cfg_if.cfg_ready, 1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = 2'd0;
    chk("e_err", status[7], 1);
    chk("e_pend", status[1:0], 0);
    wait_ce(0, ta);
    wait_ce(0, tb);
    chk("e_ch0_gap", tb - ta, 4);
    repeat (5) @(negedge clk);
    chk("e_sticky", status[7], 1);

    // disable with pending set: immediate apply
    wait_ce(0, t);
    chk("f_rdy", cfg_if.cfg_ready, 1);
    cfg_drive(2'd0, 8'd128);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("f_pend", status[0], 1);
    enable = 2'b10;
    @(negedge clk);
    chk("f_ph", phase[1:0], 0);
    chk("f_ce", ce[0], 0);
    chk("f_lock", locked[0], 0);
    chk("f_pend_clr", status[0], 0);
    enable = 2'b11;
    ts = cyc;
    wait_ce(0, t);
    chk("f_first", t - ts, 2);
    wait_ce(0, tb);
    chk("f_gap", tb - t, 2);

    // async reset while a ce is high
    chk("g_err_pre", status[7], 1);
    wait_ce(1, t);
    #1 reset_n = 1'b0;
    #1;
    chk("g_ce", ce, 0);
    chk("g_phase", phase, 0);
    chk("g_locked", locked, 0);
    chk("g_status", status, 0);
    repeat (2) @(negedge clk);
    chk("g_ce_hold", ce, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("g_rdy", cfg_if.cfg_ready, 1);
    wait_ce(1, ta);
    wait_ce(1, tb);
    chk("g_default", tb - ta, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
